rgb_byte_deserializer: RTL and testbench

- Receives a byte stream of colour components (R, G, B in sequence) over a valid/ready handshake and reassembles each group into one composite RGB pixel.
- Presents the pixel on an r/g/b output bundle with its own valid/ready handshake.
- Receiving end of the pixel-to-byte serialisation used by pixel sources that drive r/g/b composite outputs.
- Sits between a byte-wide link and pixel consumers.

---
 rtl/rgb_pkg.sv | 12 +
 rtl/rgb_byte_deserializer_if.sv | 10 +
 rtl/rgb_out_reg.sv | 24 ++
 rtl/rgb_byte_deserializer.sv | 56 +++++
 tb/tb_rgb_byte_deserializer.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/rgb_pkg.sv
// rgb_pkg: shared pixel types and framing constants for the RGB byte link.
package rgb_pkg;
  localparam int PIX_W = 8;
  localparam int PIXEL_BYTES = 3;
  typedef enum logic [1:0] {C0, C1, C2} phase_t;
  localparam phase_t LAST = phase_t'(PIXEL_BYTES - 1);
  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } rgb_t;
endpackage

// File: rtl/rgb_byte_deserializer_if.sv
// rgb_byte_deserializer_if: byte-in / pixel-out handshake bundle.
interface rgb_byte_deserializer_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] in_data, out_r, out_g, out_b;
  logic in_sop, in_valid, in_ready, out_valid, out_ready, sync_err;
  logic [15:0] pixel_cnt;
  modport master(output in_data, in_sop, in_valid, out_ready,
                 input in_ready, out_r, out_g, out_b, out_valid, sync_err, pixel_cnt);
  modport slave(input in_data, in_sop, in_valid, out_ready,
                output in_ready, out_r, out_g, out_b, out_valid, sync_err, pixel_cnt);
endinterface

// File: rtl/rgb_out_reg.sv
// rgb_out_reg: single-entry valid/ready pipeline register carrying one pixel.
module rgb_out_reg
  import rgb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  rgb_t in_pix,
  output logic out_valid,
  input  logic out_ready,
  output rgb_t out_pix
);
  // Accepts a new pixel in the same cycle the held one drains.
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      out_pix   <= '0;
    end else begin
      out_valid <= (in_valid && in_ready) || (out_valid && !out_ready);
      if (in_valid && in_ready) out_pix <= in_pix;
    end
endmodule

// File: rtl/rgb_byte_deserializer.sv
// rgb_byte_deserializer: reassembles R,G,B component bytes into composite pixels.
module rgb_byte_deserializer
  import rgb_pkg::*;
#(
  parameter int DATA_WIDTH = PIX_W,
  parameter bit BGR_ORDER  = 1'b0
) (
  input logic clk,
  input logic rst,
  rgb_byte_deserializer_if.slave bus
);
  phase_t phase, phase_nx;
  logic [DATA_WIDTH-1:0] hold0, hold1;
  logic [15:0] cnt;
  logic hs, resync, load, reg_ready, err;
  rgb_t pix_in, pix;
  always_ff @(posedge clk or posedge rst)
    if (rst) phase <= C0;
    else phase <= phase_nx;
  always_comb begin
    hs       = bus.in_valid && bus.in_ready;
    resync   = hs && bus.in_sop && phase != C0;
    load     = hs && phase == LAST && !resync;
    phase_nx = !hs ? phase : resync ? C1 : phase == LAST ? C0 : phase_t'(phase + 2'd1);
  end
  // Only the final byte can stall, and only while the output slot is occupied.
  assign bus.in_ready = phase != LAST || reg_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hold0 <= '0;
      hold1 <= '0;
      err   <= 1'b0;
      cnt   <= '0;
    end else begin
      err <= resync;
      if (hs && (phase == C0 || resync)) hold0 <= bus.in_data;
      if (hs && phase == C1 && !resync) hold1 <= bus.in_data;
      if (bus.out_valid && bus.out_ready) cnt <= cnt + 16'd1;
    end
  assign pix_in = BGR_ORDER ? {bus.in_data, hold1, hold0} : {hold0, hold1, bus.in_data};
  rgb_out_reg u_out (
    .clk(clk),
    .rst(rst),
    .in_valid(load),
    .in_ready(reg_ready),
    .in_pix(pix_in),
    .out_valid(bus.out_valid),
    .out_ready(bus.out_ready),
    .out_pix(pix)
  );
  assign bus.out_r     = pix.r;
  assign bus.out_g     = pix.g;
  assign bus.out_b     = pix.b;
  assign bus.sync_err  = err;
  assign bus.pixel_cnt = cnt;
endmodule

// File: tb/tb_rgb_byte_deserializer.sv
// tb_rgb_byte_deserializer: table, directed and random checks of both wire orders.
module tb_rgb_byte_deserializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rgb_byte_deserializer_if b0 ();
  rgb_byte_deserializer_if b1 ();
  assign b1.in_data   = b0.in_data;
  assign b1.in_sop    = b0.in_sop;
  assign b1.in_valid  = b0.in_valid;
  assign b1.out_ready = b0.out_ready;

  rgb_byte_deserializer #(.BGR_ORDER(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  rgb_byte_deserializer #(.BGR_ORDER(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]  part[$];
  logic [23:0] exp_q[$];
  logic        err_exp = 1'b0;
  logic [15:0] cnt = '0;

  typedef struct {
    logic [7:0] d0, d1, d2;
    logic [23:0] rgb0, rgb1;
  } vec_t;
  vec_t tv[5];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endfunction

  // Reference: a pixel is simply the last three accepted bytes since a start or resync.
  task automatic tick();
    logic rdy_exp;
    @(negedge clk);
    if (!rst) begin
      rdy_exp = !(part.size() == 2 && exp_q.size() != 0 && !b0.out_ready);
      chk("in_ready", 32'(b0.in_ready), 32'(rdy_exp));
      chk("in_ready_bgr", 32'(b1.in_ready), 32'(rdy_exp));
      chk("out_valid", 32'(b0.out_valid), 32'(exp_q.size() != 0));
      chk("out_valid_bgr", 32'(b1.out_valid), 32'(exp_q.size() != 0));
      chk("sync_err", 32'(b0.sync_err), 32'(err_exp));
      chk("sync_err_bgr", 32'(b1.sync_err), 32'(err_exp));
      chk("pixel_cnt", 32'(b0.pixel_cnt), 32'(cnt));
      chk("pixel_cnt_bgr", 32'(b1.pixel_cnt), 32'(cnt));
      if (exp_q.size() != 0) begin
        chk("pix_rgb", 32'({b0.out_r, b0.out_g, b0.out_b}), 32'(exp_q[0]));
        chk("pix_bgr", 32'({b1.out_r, b1.out_g, b1.out_b}),
            32'({exp_q[0][7:0], exp_q[0][15:8], exp_q[0][23:16]}));
        if (b0.out_ready) begin
          void'(exp_q.pop_front());
          cnt++;
        end
      end
      err_exp = 1'b0;
      if (b0.in_valid && rdy_exp) begin
        if (b0.in_sop && part.size() != 0) begin
          err_exp = 1'b1;
          part.delete();
        end
        part.push_back(b0.in_data);
        if (part.size() == 3) begin
          exp_q.push_back({part[0], part[1], part[2]});
          part.delete();
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] d, input logic s, input logic ordy);
    b0.in_valid  = 1'b1;
    b0.in_data   = d;
    b0.in_sop    = s;
    b0.out_ready = ordy;
    tick();
    b0.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    b0.in_valid  = 1'b0;
    b0.out_ready = 1'b1;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    b0.in_valid  = 1'b0;
    b0.in_sop    = 1'b0;
    b0.in_data   = '0;
    b0.out_ready = 1'b0;
    part.delete();
    exp_q.delete();
    err_exp = 1'b0;
    cnt     = '0;
    #1;
    chk("rst_in_ready", 32'(b0.in_ready), 32'd1);
    chk("rst_out_valid", 32'(b0.out_valid), 32'd0);
    chk("rst_out_valid_bgr", 32'(b1.out_valid), 32'd0);
    chk("rst_pix", 32'({b0.out_r, b0.out_g, b0.out_b}), 32'd0);
    chk("rst_sync_err", 32'(b0.sync_err), 32'd0);
    chk("rst_pixel_cnt", 32'(b0.pixel_cnt), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    tv[0] = '{8'h00, 8'h01, 8'h02, 24'h000102, 24'h020100};
    tv[1] = '{8'h10, 8'h11, 8'h12, 24'h101112, 24'h121110};
    tv[2] = '{8'h13, 8'h14, 8'h15, 24'h131415, 24'h151413};
    tv[3] = '{8'h12, 8'h11, 8'h10, 24'h121110, 24'h101112};
    tv[4] = '{8'hFF, 8'h00, 8'hA5, 24'hFF00A5, 24'hA500FF};
    do_reset();
    idle(2);

    foreach (tv[i]) begin
      put(tv[i].d0, 1'b1, 1'b1);
      put(tv[i].d1, 1'b0, 1'b1);
      put(tv[i].d2, 1'b0, 1'b1);
      chk("tbl_valid", 32'(b0.out_valid), 32'd1);
      chk("tbl_rgb", 32'({b0.out_r, b0.out_g, b0.out_b}), 32'(tv[i].rgb0));
      chk("tbl_bgr", 32'({b1.out_r, b1.out_g, b1.out_b}), 32'(tv[i].rgb1));
    end
    idle(2);
    chk("tbl_cnt", 32'(b0.pixel_cnt), 32'd5);

    put(8'h20, 1'b1, 1'b1);
    put(8'h21, 1'b0, 1'b1);
    put(8'h22, 1'b0, 1'b0);
    put(8'h30, 1'b1, 1'b0);
    put(8'h31, 1'b0, 1'b0);
    b0.in_valid = 1'b1;
    b0.in_data  = 8'h32;
    b0.in_sop   = 1'b0;
    repeat (3) tick();
    chk("bp_in_ready", 32'(b0.in_ready), 32'd0);
    chk("bp_hold", 32'({b0.out_r, b0.out_g, b0.out_b}), 32'h202122);
    b0.out_ready = 1'b1;
    tick();
    b0.in_valid = 1'b0;
    chk("bp_reload", 32'({b0.out_r, b0.out_g, b0.out_b}), 32'h303132);
    chk("bp_valid", 32'(b0.out_valid), 32'd1);
    idle(2);

    put(8'hAA, 1'b1, 1'b1);
    put(8'hBB, 1'b0, 1'b1);
    put(8'h10, 1'b1, 1'b1);
    chk("resync_err", 32'(b0.sync_err), 32'd1);
    put(8'h11, 1'b0, 1'b1);
    chk("resync_err_clear", 32'(b0.sync_err), 32'd0);
    put(8'h12, 1'b0, 1'b1);
    chk("resync_pix", 32'({b0.out_r, b0.out_g, b0.out_b}), 32'h101112);
    idle(2);

    put(8'h40, 1'b1, 1'b0);
    put(8'h41, 1'b0, 1'b0);
    put(8'h42, 1'b0, 1'b0);
    put(8'h50, 1'b1, 1'b0);
    put(8'h51, 1'b0, 1'b0);
    do_reset();
    put(8'h60, 1'b1, 1'b1);
    put(8'h61, 1'b0, 1'b1);
    put(8'h62, 1'b0, 1'b1);
    chk("post_rst_pix", 32'({b0.out_r, b0.out_g, b0.out_b}), 32'h606162);
    idle(2);

    force dut0.cnt = 16'hFFFF;
    force dut1.cnt = 16'hFFFF;
    #1;
    release dut0.cnt;
    release dut1.cnt;
    cnt = 16'hFFFF;
    idle(1);
    put(8'h70, 1'b1, 1'b1);
    put(8'h71, 1'b0, 1'b1);
    put(8'h72, 1'b0, 1'b1);
    idle(2);
    chk("cnt_wrap", 32'(b0.pixel_cnt), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      b0.in_valid  = $urandom_range(0, 3) != 0;
      b0.in_data   = 8'($urandom);
      b0.in_sop    = $urandom_range(0, 7) == 0 || (part.size() == 0 && $urandom_range(0, 1) == 1);
      b0.out_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
